// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the instruction-fetch front end: the encodings
// of the NOP and HALT opcode, and the fetch FSM state type.
package fetch_stage_pkg;

  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;
  localparam logic [4:0]  HALT_OPC_DEF  = 5'b00000;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  function automatic logic [15:0] pc_plus2(input logic [15:0] a);
    return a + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding register for an instruction (and its PC+2) that arrived
// while decode was stalled. Clear wins over load.
module fetch_hold_buf
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc2_in,
  output logic [15:0] instr,
  output logic [15:0] pc2
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr <= NOP_INSTR;
      pc2   <= 16'h0000;
    end else if (clear) begin
      instr <= NOP_INSTR;
      pc2   <= 16'h0000;
    end else if (load) begin
      instr <= instr_in;
      pc2   <= pc2_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, runs the imem request/response
// handshake and presents PC+2 / instruction pairs to the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [4:0]  HALT_OPC  = HALT_OPC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [15:0]  imem_addr,
  input  logic         imem_done,
  input  logic [15:0]  imem_data,
  input  logic         stall_in,
  input  logic         redirect_valid,
  input  logic [15:0]  redirect_pc,
  output logic [15:0]  pc_next_out,
  output logic [15:0]  instruction_out,
  output logic         valid_out,
  output logic         halted,
  output fetch_state_t state_dbg
);

  // Handshake: imem_req stays high with imem_addr stable until the one-cycle
  // imem_done pulse; valid_out means IF/ID takes the word this very cycle.
  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  req_addr;
  logic         squash;
  logic [15:0]  hold_instr;
  logic [15:0]  hold_pc2;

  logic [15:0] redirect_tgt;
  logic [15:0] req_pc2;
  logic        fetch_take;
  logic        accept_fetch;
  logic        capture;
  logic        hold_show;
  logic        accept_hold;
  logic        fetch_is_halt;
  logic        hold_is_halt;

  assign redirect_tgt  = redirect_pc & ~16'h0001;
  assign req_pc2       = pc_plus2(req_addr);
  assign fetch_take    = (state == ST_FETCH) && imem_done && !squash && !redirect_valid;
  assign accept_fetch  = fetch_take && !stall_in;
  assign capture       = fetch_take && stall_in;
  assign hold_show     = (state == ST_HOLD) && !redirect_valid;
  assign accept_hold   = hold_show && !stall_in;
  assign fetch_is_halt = (imem_data[15:11] == HALT_OPC);
  assign hold_is_halt  = (hold_instr[15:11] == HALT_OPC);

  fetch_hold_buf #(.NOP_INSTR(NOP_INSTR)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (capture),
    .clear    (redirect_valid),
    .instr_in (imem_data),
    .pc2_in   (req_pc2),
    .instr    (hold_instr),
    .pc2      (hold_pc2)
  );

  always_comb begin
    imem_req        = (state == ST_FETCH);
    imem_addr       = req_addr;
    halted          = (state == ST_HALTED);
    valid_out       = accept_fetch || accept_hold;
    state_dbg       = state;
    instruction_out = NOP_INSTR;
    pc_next_out     = pc_plus2(pc);
    if (accept_fetch) begin
      instruction_out = imem_data;
      pc_next_out     = req_pc2;
    end else if (hold_show) begin
      instruction_out = hold_instr;
      pc_next_out     = hold_pc2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      squash   <= 1'b0;
    end else if (redirect_valid) begin
      pc    <= redirect_tgt;
      state <= ST_FETCH;
      // An in-flight request cannot be cancelled; its word is dropped on return.
      if (state != ST_FETCH || imem_done) begin
        req_addr <= redirect_tgt;
        squash   <= 1'b0;
      end else begin
        squash   <= 1'b1;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_done) begin
            if (squash) begin
              req_addr <= pc;
              squash   <= 1'b0;
            end else if (!stall_in) begin
              pc       <= req_pc2;
              req_addr <= req_pc2;
              if (fetch_is_halt) state <= ST_HALTED;
            end else begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall_in) begin
            pc       <= hold_pc2;
            req_addr <= hold_pc2;
            state    <= hold_is_halt ? ST_HALTED : ST_FETCH;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: wait-state memory model, directed
// scenarios, then randomized stall/redirect/wait traffic against a PC-walk model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [15:0] NOP_WORD = 16'h0800;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_req;
  logic [15:0]  imem_addr;
  logic         imem_done;
  logic [15:0]  imem_data;
  logic         stall_in;
  logic         redirect_valid;
  logic [15:0]  redirect_pc;
  logic [15:0]  pc_next_out;
  logic [15:0]  instruction_out;
  logic         valid_out;
  logic         halted;
  fetch_state_t state_dbg;

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_done       (imem_done),
    .imem_data       (imem_data),
    .stall_in        (stall_in),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .pc_next_out     (pc_next_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out),
    .halted          (halted),
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- memory model ----------------
  logic [15:0] mem [0:32767];
  int          mem_wait;
  int          wait_cnt;

  assign imem_done = rst && imem_req && (wait_cnt >= mem_wait);
  assign imem_data = mem[imem_addr[15:1]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       wait_cnt <= 0;
    else if (imem_req && !imem_done) wait_cnt <= wait_cnt + 1;
    else                             wait_cnt <= 0;
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {halt, pc_next, instr}
  int n_checks = 0;
  int n_pass   = 0;
  int n_accept = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: accepted words walk memory upward from the start address
  // (bit 0 cleared, 16-bit wrap) and stop after a word with opcode 00000.
  task automatic push_stream(input logic [15:0] start);
    logic [15:0] a;
    logic [15:0] w;
    a = start & 16'hFFFE;
    for (int i = 0; i < 200; i++) begin
      w = mem[a[15:1]];
      exp_q.push_back({(w[15:11] == 5'b00000), a + 16'd2, w});
      if (w[15:11] == 5'b00000) break;
      a = a + 16'd2;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic        prev_wait;
    logic [15:0] prev_addr;
    logic        halt_pend;
    logic [32:0] e;
    prev_wait = 1'b0;
    prev_addr = '0;
    halt_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_wait = 1'b0;
        halt_pend = 1'b0;
      end else begin
        if (prev_wait) begin
          check("req_held", imem_req, 1);
          check("addr_stable", imem_addr, prev_addr);
        end
        if (halt_pend) begin
          check("halted_flag", halted, 1);
          check("halted_noreq", imem_req, 0);
          halt_pend = 1'b0;
        end
        if (valid_out) begin
          n_accept++;
          check("valid_vs_stall", stall_in, 0);
          check("valid_vs_redirect", redirect_valid, 0);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_valid: got instr %0h pc_next %0h, expected no acceptance (t=%0t)",
                     instruction_out, pc_next_out, $time);
          end else begin
            e = exp_q.pop_front();
            check("pc_next", pc_next_out, e[31:16]);
            check("instr", instruction_out, e[15:0]);
            if (e[32]) halt_pend = 1'b1;
          end
        end
        prev_wait = imem_req && !imem_done;
        prev_addr = imem_addr;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [15:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    exp_q.delete();
    push_stream(t);
    tick();
    redirect_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] w;
    logic        found;
    int          nw;
    int          since;
    rst            = 1'b0;
    stall_in       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_wait       = 2;
    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      if (w[15:11] == 5'b00000) w[15:11] = 5'b10101;
      mem[i] = w;
    end
    mem[0]       = 16'h4000;
    mem[1]       = 16'h4100;
    mem[2]       = 16'h4200;
    mem[16'h18]  = 16'h0000;   // HALT at address 0x0030
    mem[16'h7FFF] = 16'h5A5A;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_valid", valid_out, 0);
    check("rst_halted", halted, 0);
    check("rst_state", state_dbg, ST_FETCH);

    // zero-wait memory: one acceptance per cycle from pc 0
    tick();
    push_stream(16'h0000);
    mem_wait = 0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("zw_req", imem_req, 1);
      check("zw_addr", imem_addr, 16'(2 * k));
      check("zw_valid", valid_out, 1);
      tick();
    end

    // redirect to 0x0101 while a 3-wait request at 0x0010 is outstanding
    mem_wait = 3;
    do_redirect(16'h0010);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 16'h0010) begin found = 1'b1; break; end
      tick();
    end
    check("sq_setup", found, 1);
    tick();
    do_redirect(16'h0101);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_addr != 16'h0010) break;
      check("sq_novalid", valid_out, 0);
      tick();
    end
    check("sq_addr", imem_addr, 16'h0100);
    check("sq_req", imem_req, 1);

    // 3-wait request at 0x0100: address held, valid in done cycle, next request follows
    nw = 0;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (imem_done) begin
        check("w3_valid", valid_out, 1);
        found = 1'b1;
        break;
      end
      check("w3_novalid", valid_out, 0);
      nw++;
      tick();
      @(negedge clk);
    end
    check("w3_done_seen", found, 1);
    check("w3_wait", nw, 3);
    tick();
    @(negedge clk);
    check("w3_next_addr", imem_addr, 16'h0102);
    check("w3_next_req", imem_req, 1);
    tick();

    // stall for two cycles over a done
    mem_wait = 0;
    repeat (3) tick();
    stall_in = 1'b1;
    @(negedge clk);
    check("st_cap_valid", valid_out, 0);
    check("st_cap_req", imem_req, 1);
    tick();
    @(negedge clk);
    check("st_hold_req", imem_req, 0);
    check("st_hold_valid", valid_out, 0);
    if (exp_q.size() > 0) check("st_hold_instr", instruction_out, {16'h0, exp_q[0][15:0]});
    tick();
    stall_in = 1'b0;
    @(negedge clk);
    check("st_accept", valid_out, 1);
    tick();

    // HALT fetch, then resume by redirect
    do_redirect(16'h002C);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (halted) begin found = 1'b1; break; end
      tick();
    end
    check("halt_seen", found, 1);
    tick();
    @(negedge clk);
    check("halt_req", imem_req, 0);
    check("halt_valid", valid_out, 0);
    check("halt_instr", instruction_out, NOP_WORD);
    tick();
    do_redirect(16'h0020);
    @(negedge clk);
    check("resume_addr", imem_addr, 16'h0020);
    check("resume_req", imem_req, 1);
    check("resume_halted", halted, 0);
    tick();

    // wrap at top of address space
    do_redirect(16'hFFFE);
    @(negedge clk);
    check("wrap_addr", imem_addr, 16'hFFFE);
    check("wrap_pc2", pc_next_out, 16'h0000);
    tick();
    @(negedge clk);
    check("wrap_next", imem_addr, 16'h0000);
    tick();

    // asynchronous reset in the middle of a request
    mem_wait = 3;
    do_redirect(16'h0200);
    tick();
    rst = 1'b0;
    #1;
    check("arst_addr", imem_addr, 16'h0000);
    check("arst_valid", valid_out, 0);
    check("arst_halted", halted, 0);
    exp_q.delete();
    tick();
    tick();
    push_stream(16'h0000);
    mem_wait = 1;
    rst = 1'b1;
    @(negedge clk);
    check("arst_rel_req", imem_req, 1);
    check("arst_rel_addr", imem_addr, 16'h0000);
    tick();

    // randomized traffic
    since = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 9) == 0) mem_wait = $urandom_range(0, 3);
      stall_in = ($urandom_range(0, 3) == 0);
      if (since >= 120 || $urandom_range(0, 24) == 0) begin
        do_redirect(16'($urandom_range(0, 65535)));
        since = 0;
      end else begin
        tick();
        since++;
      end
    end
    stall_in = 1'b0;
    repeat (5) tick();
    check("progress", (n_accept > 200), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
